mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory-stage controller: passes ALU results through, or runs one data-bus
// transaction per load/store while holding the pipeline with a stall request.
module mem_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] result_i,
    input  logic [31:0] store_i,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic [4:0]  r_waddr;
    logic        r_is_load;
    logic        r_is_store;
    logic        r_is_word;
    logic        r_is_signed;
    logic [31:0] r_rdata;
    logic        r_ok;

    logic        w_in_load;
    logic        w_in_store;
    logic        w_in_word;
    logic        w_in_misalign;
    logic        w_start;
    logic [7:0]  w_lane;
    logic [31:0] w_load_val;
    logic [3:0]  w_sel;
    logic        w_timeout;

    assign w_in_load     = (aluop_i == OP_LB) || (aluop_i == OP_LW) || (aluop_i == OP_LBU);
    assign w_in_store    = (aluop_i == OP_SB) || (aluop_i == OP_SW);
    assign w_in_word     = (aluop_i == OP_LW) || (aluop_i == OP_SW);
    assign w_in_misalign = w_in_word && (result_i[1:0] != 2'b00);
    assign w_start       = (w_in_load || w_in_store) && !w_in_misalign;

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        w_lane = 8'h00;
        case (r_addr[1:0])
            2'd0: w_lane = bus_rdata_i[31:24];
            2'd1: w_lane = bus_rdata_i[23:16];
            2'd2: w_lane = bus_rdata_i[15:8];
            default: w_lane = bus_rdata_i[7:0];
        endcase
    end

    assign w_load_val = r_is_word   ? bus_rdata_i :
                        r_is_signed ? {{24{w_lane[7]}}, w_lane} :
                                      {24'h000000, w_lane};
    assign w_sel      = r_is_word ? 4'b1111 : (4'b1000 >> r_addr[1:0]);
    assign w_timeout  = (r_cnt == TO_LAST);
    assign dbg_state_o = r_state;

    // Outputs and next state; everything is forced low while rst is high.
    always_comb begin
        w_next      = r_state;
        we_o        = 1'b0;
        waddr_o     = 5'd0;
        wdata_o     = 32'd0;
        stall_req_o = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = 32'd0;
        bus_wdata_o = 32'd0;
        bus_sel_o   = 4'b0000;
        align_err_o = 1'b0;
        bus_err_o   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        stall_req_o = 1'b1;
                        w_next      = S_BUS;
                    end else if (w_in_misalign) begin
                        align_err_o = 1'b1;
                    end else if (!w_in_load && !w_in_store) begin
                        we_o    = we_i;
                        waddr_o = waddr_i;
                        wdata_o = result_i;
                    end
                end
                S_BUS: begin
                    stall_req_o = 1'b1;
                    bus_req_o   = 1'b1;
                    bus_we_o    = r_is_store;
                    bus_addr_o  = {r_addr[31:2], 2'b00};
                    bus_sel_o   = w_sel;
                    if (r_is_store)
                        bus_wdata_o = r_is_word ? r_store : {4{r_store[7:0]}};
                    if (bus_ack_i) begin
                        w_next = S_DONE;
                    end else if (w_timeout) begin
                        bus_err_o = 1'b1;
                        w_next    = S_DONE;
                    end
                end
                S_DONE: begin
                    we_o    = r_ok;
                    waddr_o = r_ok ? r_waddr : 5'd0;
                    wdata_o = r_ok ? r_rdata : 32'd0;
                    w_next  = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_addr      <= 32'd0;
            r_store     <= 32'd0;
            r_waddr     <= 5'd0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_word   <= 1'b0;
            r_is_signed <= 1'b0;
            r_rdata     <= 32'd0;
            r_ok        <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr      <= result_i;
                        r_store     <= store_i;
                        r_waddr     <= waddr_i;
                        r_is_load   <= w_in_load;
                        r_is_store  <= w_in_store;
                        r_is_word   <= w_in_word;
                        r_is_signed <= (aluop_i == OP_LB);
                        r_cnt       <= 8'd0;
                        r_ok        <= 1'b0;
                    end
                end
                S_BUS: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (bus_ack_i) begin
                        r_ok    <= r_is_load;
                        r_rdata <= w_load_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: the driver pushes expected write-backs, bus
// requests and error pulses into queues; a negedge monitor pops and compares.
module tb_mem_ctrl;

    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SW  = 8'hEB;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] result_i;
    logic [31:0] store_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        align_err_o;
    logic        bus_err_o;
    logic [1:0]  dbg_state_o;

    int checks;
    int failures;
    bit mon_en;
    bit prev_req;

    logic [36:0] exp_wb_q[$];
    logic [68:0] exp_bus_q[$];
    logic [1:0]  exp_err_q[$];

    mem_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .we_i(we_i), .waddr_i(waddr_i),
        .result_i(result_i), .store_i(store_i), .we_o(we_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .stall_req_o(stall_req_o), .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_sel_o(bus_sel_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .align_err_o(align_err_o), .bus_err_o(bus_err_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (we_o) begin
                if (exp_wb_q.size() == 0) check("wb_unexpected", 69'({waddr_o, wdata_o}), 69'h0);
                else check("wb", 69'({waddr_o, wdata_o}), 69'(exp_wb_q.pop_front()));
            end
            if (bus_req_o && !prev_req) begin
                if (exp_bus_q.size() == 0)
                    check("bus_unexpected", {bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o}, 69'h0);
                else
                    check("bus_req", {bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o}, exp_bus_q.pop_front());
            end
            if (align_err_o || bus_err_o) begin
                if (exp_err_q.size() == 0) check("err_unexpected", 69'({align_err_o, bus_err_o}), 69'h0);
                else check("err", 69'({align_err_o, bus_err_o}), 69'(exp_err_q.pop_front()));
            end
        end
        prev_req = bus_req_o;
    end

    // driver tasks
    task automatic idle_inputs();
        aluop_i     = 8'h00;
        we_i        = 1'b0;
        waddr_i     = 5'd0;
        result_i    = 32'd0;
        store_i     = 32'd0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
    endtask

    // Called just after a rising edge with the DUT in IDLE. ack_at = BUS cycle
    // (1-based) on which to acknowledge, 0 = never.
    task automatic run_op(input string name, input logic [7:0] op, input logic we,
                          input logic [4:0] wa, input logic [31:0] res, input logic [31:0] st,
                          input int ack_at, input logic [31:0] rdata, input int exp_stall);
        int stalls;
        bit done;
        stalls = 0;
        done = 1'b0;
        aluop_i  = op;
        we_i     = we;
        waddr_i  = wa;
        result_i = res;
        store_i  = st;
        for (int c = 0; c < 40 && !done; c++) begin
            bus_ack_i   = (c > 0) && (c == ack_at);
            bus_rdata_i = bus_ack_i ? rdata : 32'h5A5A_5A5A;
            @(negedge clk);
            if (!stall_req_o) done = 1'b1;
            else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        check({name, "_stall_cycles"}, 69'(stalls), 69'(exp_stall));
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        mon_en = 1'b0;
        prev_req = 1'b0;

        // Reset dominates even with a live aligned load and an ack present.
        rst = 1'b1;
        idle_inputs();
        aluop_i = OP_LW; we_i = 1'b1; waddr_i = 5'd3; result_i = 32'h100; bus_ack_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 69'({we_o, waddr_o, wdata_o, stall_req_o, bus_req_o, bus_we_o, bus_sel_o,
                                    align_err_o, bus_err_o}), 69'h0);
        check("reset_bus_data", 69'({bus_addr_o, bus_wdata_o}), 69'h0);
        check("reset_state", 69'(dbg_state_o), 69'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        mon_en = 1'b1;

        // Non-memory op passes straight through.
        exp_wb_q.push_back({5'd5, 32'h0000_00FF});
        run_op("or_pass", OP_OR, 1'b1, 5'd5, 32'h0000_00FF, 32'h0, 0, 32'h0, 0);

        exp_bus_q.push_back({1'b0, 32'h100, 32'h0, 4'b1111});
        exp_wb_q.push_back({5'd7, 32'hDEAD_BEEF});
        run_op("lw_ack3", OP_LW, 1'b1, 5'd7, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 4);

        exp_bus_q.push_back({1'b0, 32'h100, 32'h0, 4'b0001});
        exp_wb_q.push_back({5'd8, 32'hFFFF_FFF0});
        run_op("lb_off3", OP_LB, 1'b1, 5'd8, 32'h103, 32'h0, 1, 32'h0000_00F0, 2);

        exp_bus_q.push_back({1'b0, 32'h100, 32'h0, 4'b0001});
        exp_wb_q.push_back({5'd9, 32'h0000_00F0});
        run_op("lbu_off3", OP_LBU, 1'b1, 5'd9, 32'h103, 32'h0, 1, 32'h0000_00F0, 2);

        exp_bus_q.push_back({1'b1, 32'h200, 32'h7878_7878, 4'b0100});
        run_op("sb_off1", OP_SB, 1'b1, 5'd10, 32'h201, 32'h1234_5678, 1, 32'h0, 2);

        exp_bus_q.push_back({1'b1, 32'h300, 32'hCAFE_BABE, 4'b1111});
        run_op("sw_ack2", OP_SW, 1'b0, 5'd0, 32'h300, 32'hCAFE_BABE, 2, 32'h0, 3);

        exp_err_q.push_back(2'b10);
        run_op("sw_misalign", OP_SW, 1'b0, 5'd0, 32'h102, 32'h1111_2222, 0, 32'h0, 0);

        exp_bus_q.push_back({1'b0, 32'h104, 32'h0, 4'b1111});
        exp_err_q.push_back(2'b01);
        run_op("lw_timeout", OP_LW, 1'b1, 5'd11, 32'h104, 32'h0, 0, 32'h0, 16);

        // Ack on the last allowed cycle wins over the timeout.
        exp_bus_q.push_back({1'b0, 32'h108, 32'h0, 4'b1111});
        exp_wb_q.push_back({5'd12, 32'h1122_3344});
        run_op("lw_ack_at_limit", OP_LW, 1'b1, 5'd12, 32'h108, 32'h0, 15, 32'h1122_3344, 16);

        exp_bus_q.push_back({1'b0, 32'h400, 32'h0, 4'b1000});
        exp_wb_q.push_back({5'd13, 32'hFFFF_FF80});
        run_op("lb_off0", OP_LB, 1'b1, 5'd13, 32'h400, 32'h0, 1, 32'h8012_3456, 2);

        exp_bus_q.push_back({1'b0, 32'h400, 32'h0, 4'b0100});
        exp_wb_q.push_back({5'd14, 32'h0000_0012});
        run_op("lbu_off1", OP_LBU, 1'b1, 5'd14, 32'h401, 32'h0, 2, 32'h8012_3456, 3);

        exp_bus_q.push_back({1'b0, 32'h400, 32'h0, 4'b0010});
        exp_wb_q.push_back({5'd15, 32'h0000_0034});
        run_op("lb_off2", OP_LB, 1'b1, 5'd15, 32'h402, 32'h0, 1, 32'h8012_3456, 2);

        exp_bus_q.push_back({1'b1, 32'h200, 32'hABAB_ABAB, 4'b0001});
        run_op("sb_off3", OP_SB, 1'b0, 5'd0, 32'h203, 32'h0000_00AB, 1, 32'h0, 2);

        // Reset in BUS cycle 2 aborts the load; later acks must do nothing.
        exp_bus_q.push_back({1'b0, 32'h500, 32'h0, 4'b1111});
        aluop_i = OP_LW; we_i = 1'b1; waddr_i = 5'd9; result_i = 32'h500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("abort_outputs", 69'({we_o, stall_req_o, bus_req_o, bus_err_o, align_err_o}), 69'h0);
        check("abort_state", 69'(dbg_state_o), 69'h0);
        @(posedge clk); #1;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hFFFF_0000;
        repeat (3) @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_state_after", 69'(dbg_state_o), 69'h0);

        check("wb_queue_empty", 69'(exp_wb_q.size()), 69'h0);
        check("bus_queue_empty", 69'(exp_bus_q.size()), 69'h0);
        check("err_queue_empty", 69'(exp_err_q.size()), 69'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
